// File: rtl/conv_pkg.sv
// conv_pkg: shared word width and loader state encoding
package conv_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {LOAD_FILTER, LOAD_INPUT, PRESENT} state_t;
endpackage

// File: rtl/conv_frame_loader.sv
// conv_frame_loader: assembles a filter block and an input frame from one word stream; CONV_LOADER_LAST_CHECK_EN enables the sticky s_last framing error
module conv_frame_loader
    import conv_pkg::*;
#(
    parameter int input_size  = 7,
    parameter int filter_size = 3
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               s_valid,
    output logic                                               s_ready,
    input  logic [WORD_W-1:0]                                  s_data,
    input  logic                                               s_last,
    input  logic                                               reload_filter,
    output logic [input_size*input_size-1:0][WORD_W-1:0]       input_data,
    output logic [filter_size*filter_size-1:0][WORD_W-1:0]     filter,
    output logic                                               frame_valid,
    input  logic                                               frame_ready,
    output logic                                               err
);
    localparam int IN_N  = input_size * input_size;
    localparam int FL_N  = filter_size * filter_size;
    localparam int CNT_W = $clog2(IN_N);
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             armed, acc, last_word;
    assign s_ready     = armed && state != PRESENT;
    assign frame_valid = state == PRESENT;
    assign acc         = s_valid && s_ready;
    assign last_word   = (state == LOAD_FILTER) ? cnt == CNT_W'(FL_N - 1) : cnt == CNT_W'(IN_N - 1);
    // next state: advance on the final word of a phase, leave PRESENT on the downstream handshake
    always_comb begin
        state_n = state;
        if (state == PRESENT) begin
            if (frame_ready) state_n = reload_filter ? LOAD_FILTER : LOAD_INPUT;
        end else if (acc && last_word) begin
            state_n = (state == LOAD_FILTER) ? LOAD_INPUT : PRESENT;
        end
    end
    // state, word counter (cleared on every transition) and post-reset ready arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_FILTER;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : acc ? cnt + 1'b1 : cnt;
            armed <= 1'b1;
        end
    end
    // write each accepted word into the array slot selected by phase and count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filter     <= '0;
            input_data <= '0;
        end else if (acc) begin
            for (int i = 0; i < FL_N; i++)
                if (state == LOAD_FILTER && cnt == CNT_W'(i)) filter[i] <= s_data;
            for (int i = 0; i < IN_N; i++)
                if (state == LOAD_INPUT && cnt == CNT_W'(i)) input_data[i] <= s_data;
        end
    end
`ifdef CONV_LOADER_LAST_CHECK_EN
    // sticky flag for s_last disagreeing with the word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (acc && s_last != last_word) err <= 1'b1;
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign err         = 1'b0;
`endif
endmodule

// File: tb/tb_conv_frame_loader.sv
// tb_conv_frame_loader: randomized stream bench against an array model of the loader
module tb_conv_frame_loader;
    localparam int IS = 7;
    localparam int FS = 3;
    localparam int IN_N = IS * IS;
    localparam int FL_N = FS * FS;

    logic clk = 0, rst_n = 0, s_valid = 0, s_last = 0, reload_filter = 0, frame_ready = 0;
    logic s_ready, frame_valid, err;
    logic [31:0] s_data = 0;
    logic [IN_N-1:0][31:0] input_data;
    logic [FL_N-1:0][31:0] filter;

    logic [31:0] ef [FL_N];
    logic [31:0] ei [IN_N];
    logic exp_err = 0;
    int checks = 0, errors = 0;

    conv_frame_loader #(.input_size(IS), .filter_size(FS)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .reload_filter(reload_filter), .input_data(input_data),
        .filter(filter), .frame_valid(frame_valid), .frame_ready(frame_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l, input bit gap);
        int t;
        while (gap && $urandom_range(1) == 0) begin
            s_valid = 0;
            @(negedge clk);
        end
        s_valid = 1; s_data = d; s_last = l;
        frame_ready = 1'($urandom_range(1));
        reload_filter = 1'($urandom_range(1));
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("accept_timeout", {31'b0, s_ready}, 1);
        @(negedge clk);
    endtask

    task automatic check_frame(input string t);
        check({t, "_valid"}, {31'b0, frame_valid}, 1);
        check({t, "_ready"}, {31'b0, s_ready}, 0);
        for (int i = 0; i < FL_N; i++) check($sformatf("%s_filter[%0d]", t, i), filter[i], ef[i]);
        for (int i = 0; i < IN_N; i++) check($sformatf("%s_input[%0d]", t, i), input_data[i], ei[i]);
        check({t, "_err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic run_frame(input string t, input bit load_f, input bit gap,
                             input logic [31:0] fbase, input logic [31:0] ibase, input bit rnd, input int bad);
        logic [31:0] w;
        if (load_f) begin
            for (int i = 0; i < FL_N; i++) begin
                w = rnd ? $urandom : fbase + i;
                push(w, (i == FL_N - 1) ^ (i == bad), gap);
                ef[i] = w;
`ifdef CONV_LOADER_LAST_CHECK_EN
                if (i == bad) exp_err = 1;
`endif
                if (i == bad) check({t, "_err_set"}, {31'b0, err}, {31'b0, exp_err});
            end
            check({t, "_no_valid_after_filter"}, {31'b0, frame_valid}, 0);
        end
        for (int i = 0; i < IN_N; i++) begin
            w = rnd ? $urandom : ibase + i;
            if (i == IN_N - 1) check({t, "_valid_before_last"}, {31'b0, frame_valid}, 0);
            push(w, i == IN_N - 1, gap);
            ei[i] = w;
        end
        s_valid = 0; frame_ready = 0; reload_filter = 0;
        check_frame(t);
    endtask

    task automatic handshake(input bit reload);
        s_valid = 0; frame_ready = 1; reload_filter = reload;
        @(negedge clk);
        frame_ready = 0; reload_filter = 0;
        check("hs_valid_drop", {31'b0, frame_valid}, 0);
        check("hs_ready", {31'b0, s_ready}, 1);
    endtask

    task automatic do_reset(input string t);
        s_valid = 0;
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < FL_N; i++) ef[i] = 0;
        for (int i = 0; i < IN_N; i++) ei[i] = 0;
        exp_err = 0;
        check({t, "_filter_zero"}, {31'b0, |filter}, 0);
        check({t, "_input_zero"}, {31'b0, |input_data}, 0);
        check({t, "_valid"}, {31'b0, frame_valid}, 0);
        check({t, "_ready"}, {31'b0, s_ready}, 0);
        check({t, "_err"}, {31'b0, err}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check({t, "_ready_after"}, {31'b0, s_ready}, 1);
    endtask

    initial begin
        int r;
        @(negedge clk);
        do_reset("rst0");
        run_frame("f1", 1, 0, 1, 100, 0, -1);
        s_valid = 1; s_data = $urandom; reload_filter = 1; frame_ready = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_ready", {31'b0, s_ready}, 0);
            check("hold_valid", {31'b0, frame_valid}, 1);
            check("hold_in48", input_data[IN_N-1], ei[IN_N-1]);
            check("hold_f8", filter[FL_N-1], ef[FL_N-1]);
        end
        check_frame("hold");
        handshake(0);
        run_frame("f2", 0, 1, 0, 300, 0, -1);
        handshake(1);
        run_frame("f3", 1, 0, 200, 400, 0, -1);
        for (int k = 0; k < 3; k++) begin
            r = $urandom_range(1);
            handshake(r[0]);
            run_frame($sformatf("rnd%0d", k), r[0], 1, 0, 0, 1, -1);
        end
        handshake(0);
        for (int i = 0; i < 20; i++) push(32'h1000 + i, 0, 1);
        do_reset("rst_mid");
        run_frame("f_rst", 1, 1, 32'hABC, 32'h500, 0, -1);
        handshake(1);
        run_frame("f_err", 1, 0, 32'h600, 32'h700, 0, 4);
        handshake(0);
        run_frame("f_err2", 0, 1, 0, 32'h800, 0, -1);
        do_reset("rst_err");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
